rr_arbiter8: RTL

Round-robin arbiter that shares one 8-way resource (selected through a 3-to-8 decoder) among eight requesters. Registers the winning requester's index and enable, which drive the decoder's `a` and `en` inputs. Also provides a one-hot grant vector. Holds each grant until the owner releases it and rotates priority so no requester starves.

---
 rtl/rr_arbiter8.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters sharing one decoder-selected resource.
// Optional hold-limit revoke is compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic       gnt_en,
    output logic [7:0] gnt,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] ptr_reg, ptr_next;
    logic [2:0] gnt_idx_reg, gnt_idx_next;
    logic       gnt_en_reg, gnt_en_next;
    logic [7:0] gnt_reg, gnt_next;
    logic       timeout_reg, timeout_next;

    logic [7:0] req_rot;
    logic [2:0] win_idx;
    logic       owner_drop;
    logic       hold_hit;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arbiter8: HOLD_MAX must be in 1..255");
    end

    // Requests rotated so bit 0 is the current highest-priority requester.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        assign req_rot[gi] = req[ptr_reg + 3'(gi)];
    end

    always_comb begin
        win_idx = ptr_reg;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_idx = ptr_reg + 3'(i);
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_reg, hold_cnt_next;

    // Counter is zero whenever a grant starts because IDLE always precedes GRANT.
    assign hold_cnt_next = (state_reg == GRANT) ? hold_cnt_reg + 8'd1 : 8'd0;
    assign hold_hit      = (state_reg == GRANT) && (hold_cnt_reg == 8'(HOLD_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_reg <= 8'd0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
        end
    end
`else
    assign hold_hit = 1'b0;
`endif

    assign owner_drop = ~req[gnt_idx_reg];

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gnt_idx_next = gnt_idx_reg;
        gnt_en_next  = gnt_en_reg;
        gnt_next     = gnt_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next   = GRANT;
                    gnt_idx_next = win_idx;
                    gnt_en_next  = 1'b1;
                    gnt_next     = 8'b1 << win_idx;
                    ptr_next     = win_idx + 3'd1;
                end
            end
            GRANT: begin
                if (done || owner_drop || hold_hit) begin
                    state_next   = GAP;
                    gnt_en_next  = 1'b0;
                    gnt_next     = 8'h00;
                    // A voluntary release on the same cycle wins over the revoke.
                    timeout_next = hold_hit && !done && !owner_drop;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next  = IDLE;
                gnt_en_next = 1'b0;
                gnt_next    = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            ptr_reg     <= 3'd0;
            gnt_idx_reg <= 3'd0;
            gnt_en_reg  <= 1'b0;
            gnt_reg     <= 8'h00;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            gnt_idx_reg <= gnt_idx_next;
            gnt_en_reg  <= gnt_en_next;
            gnt_reg     <= gnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign gnt_idx = gnt_idx_reg;
    assign gnt_en  = gnt_en_reg;
    assign gnt     = gnt_reg;
    assign timeout = timeout_reg;

endmodule
